// File: rtl/command_link_if.sv
// Byte-stream side of command_link: UART receive strobe plus transmit valid/ready handshake.
interface command_link_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;

  // slave is the framing stage, master is the UART pair around it.
  modport slave  (input rx_valid, rx_byte, tx_ready, output tx_valid, tx_byte);
  modport master (output rx_valid, rx_byte, tx_ready, input tx_valid, tx_byte);
endinterface

// File: rtl/command_link.sv
// Frames UART bytes into 24-bit commands for the phase generator and serializes
// its replies back into checksummed byte frames, with one reply of buffering.
module command_link #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  CMD_SYNC       = 8'hA5,
  parameter logic [7:0]  REPLY_SYNC     = 8'h5A
) (
  input  logic          i_clk,
  input  logic          i_reset,
  command_link_if.slave link,
  output logic          o_command,
  output logic [23:0]   o_command_data,
  input  logic          i_reply,
  input  logic [23:0]   i_reply_data,
  output logic          o_overflow,
  output logic [7:0]    o_error_count
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {RX_HUNT, RX_D2, RX_D1, RX_D0, RX_CHK} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_SYNC, TX_B2, TX_B1, TX_B0, TX_CHK} tx_state_t;

  rx_state_t     rx_state_q, rx_state_d, rx_base;
  logic [TW-1:0] timer_q, timer_d;
  logic [23:0]   rx_data_q, rx_data_d;
  logic          command_d;
  logic [23:0]   command_data_d;
  logic          timeout, err_inc;

  tx_state_t     tx_state_q, tx_state_d;
  logic [23:0]   tx_word_q, tx_word_d;
  logic [23:0]   buf_q, buf_d;
  logic          buf_full_q, buf_full_d;
  logic [7:0]    tx_byte_d;
  logic          overflow_d, tx_hs, reply_started, handover;

  // A timeout and a byte in the same cycle: the byte is decoded as if in HUNT.
  assign timeout = (rx_state_q != RX_HUNT) && (timer_q == TW'(TIMEOUT_CYCLES));
  assign rx_base = timeout ? RX_HUNT : rx_state_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    rx_state_d     = rx_base;
    rx_data_d      = rx_data_q;
    command_d      = 1'b0;
    command_data_d = o_command_data;
    err_inc        = timeout;
    if (link.rx_valid) begin
      case (rx_base)
        RX_HUNT: if (link.rx_byte == CMD_SYNC) rx_state_d = RX_D2;
        RX_D2: begin
          rx_data_d[23:16] = link.rx_byte;
          rx_state_d       = RX_D1;
        end
        RX_D1: begin
          rx_data_d[15:8] = link.rx_byte;
          rx_state_d      = RX_D0;
        end
        RX_D0: begin
          rx_data_d[7:0] = link.rx_byte;
          rx_state_d     = RX_CHK;
        end
        RX_CHK: begin
          if (link.rx_byte == (rx_data_q[23:16] ^ rx_data_q[15:8] ^ rx_data_q[7:0])) begin
            command_d      = 1'b1;
            command_data_d = rx_data_q;
          end else begin
            err_inc = 1'b1;
          end
          rx_state_d = RX_HUNT;
        end
        default: rx_state_d = RX_HUNT;
      endcase
    end
    timer_d = (link.rx_valid || rx_state_d == RX_HUNT) ? '0 : timer_q + TW'(1);
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (i_reset) begin
      rx_state_q     <= RX_HUNT;
      timer_q        <= '0;
      o_command      <= 1'b0;
      o_command_data <= '0;
      o_error_count  <= '0;
    end else begin
      rx_state_q     <= rx_state_d;
      timer_q        <= timer_d;
      o_command      <= command_d;
      o_command_data <= command_data_d;
      if (err_inc && o_error_count != 8'hFF) o_error_count <= o_error_count + 8'd1;
    end
  end

  // NOTE: payload registers carry no reset; the FSM states and buf_full decide when they matter.
  always_ff @(posedge i_clk) begin
    rx_data_q <= rx_data_d;
    tx_word_q <= tx_word_d;
    buf_q     <= buf_d;
  end

  assign tx_hs = link.tx_valid && link.tx_ready;

  always_comb begin
    tx_state_d    = tx_state_q;
    tx_word_d     = tx_word_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    overflow_d    = 1'b0;
    reply_started = 1'b0;
    handover      = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (i_reply) begin
        tx_word_d     = i_reply_data;
        tx_state_d    = TX_SYNC;
        reply_started = 1'b1;
      end
      TX_SYNC: if (tx_hs) tx_state_d = TX_B2;
      TX_B2:   if (tx_hs) tx_state_d = TX_B1;
      TX_B1:   if (tx_hs) tx_state_d = TX_B0;
      TX_B0:   if (tx_hs) tx_state_d = TX_CHK;
      TX_CHK: if (tx_hs) begin
        // Chain straight into the next frame so back-to-back replies leave no gap.
        if (buf_full_q) begin
          tx_word_d  = buf_q;
          buf_full_d = 1'b0;
          tx_state_d = TX_SYNC;
          handover   = 1'b1;
        end else if (i_reply) begin
          tx_word_d     = i_reply_data;
          tx_state_d    = TX_SYNC;
          reply_started = 1'b1;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (i_reply && !reply_started) begin
      if (!buf_full_q || handover) begin
        buf_d      = i_reply_data;
        buf_full_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    case (tx_state_d)
      TX_SYNC: tx_byte_d = REPLY_SYNC;
      TX_B2:   tx_byte_d = tx_word_d[23:16];
      TX_B1:   tx_byte_d = tx_word_d[15:8];
      TX_B0:   tx_byte_d = tx_word_d[7:0];
      TX_CHK:  tx_byte_d = tx_word_d[23:16] ^ tx_word_d[15:8] ^ tx_word_d[7:0];
      default: tx_byte_d = link.tx_byte;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_state_q    <= TX_IDLE;
      buf_full_q    <= 1'b0;
      link.tx_valid <= 1'b0;
      link.tx_byte  <= '0;
      o_overflow    <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      buf_full_q    <= buf_full_d;
      link.tx_valid <= (tx_state_d != TX_IDLE);
      link.tx_byte  <= tx_byte_d;
      o_overflow    <= overflow_d;
    end
  end
endmodule

// File: tb/tb_command_link.sv
// Bench for command_link: directed frames plus random traffic, checked every cycle
// against a byte-queue reference model of the receive and reply paths.
module tb_command_link;
  localparam int unsigned T  = 20;
  localparam logic [7:0]  CS = 8'hA5;
  localparam logic [7:0]  RS = 8'h5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_command;
  logic [23:0] o_command_data;
  logic        i_reply;
  logic [23:0] i_reply_data;
  logic        o_overflow;
  logic [7:0]  o_error_count;

  command_link_if link();

  command_link #(.TIMEOUT_CYCLES(T), .CMD_SYNC(CS), .REPLY_SYNC(RS)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .link           (link),
    .o_command      (o_command),
    .o_command_data (o_command_data),
    .i_reply        (i_reply),
    .i_reply_data   (i_reply_data),
    .o_overflow     (o_overflow),
    .o_error_count  (o_error_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0, n_cmd = 0, n_ovf = 0;
  bit rand_tx = 1'b0;

  // Reference model state: frame bytes collected so far and the reply byte stream.
  int          cyc = 0, last_cyc = 0;
  bit          collecting = 1'b0;
  logic [7:0]  frame[$];
  logic [7:0]  txq[$];
  logic [7:0]  sent_q[$];
  logic [7:0]  want_q[$];
  logic        exp_cmd, exp_valid, exp_ovf;
  logic [23:0] exp_data;
  logic [7:0]  exp_err, exp_byte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bump_err();
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
  endtask

  task automatic model_step();
    logic [23:0] w;
    if (rst) begin
      collecting = 1'b0;
      frame.delete();
      txq.delete();
      exp_cmd = 1'b0; exp_data = '0; exp_err = '0;
      exp_valid = 1'b0; exp_byte = '0; exp_ovf = 1'b0;
    end else begin
      exp_cmd = 1'b0;
      exp_ovf = 1'b0;
      if (collecting && (cyc - last_cyc) > int'(T)) begin
        collecting = 1'b0;
        bump_err();
      end
      if (link.rx_valid) begin
        if (!collecting) begin
          if (link.rx_byte == CS) begin
            collecting = 1'b1;
            frame.delete();
            last_cyc = cyc;
          end
        end else begin
          frame.push_back(link.rx_byte);
          last_cyc = cyc;
          if (frame.size() == 4) begin
            collecting = 1'b0;
            if ((frame[0] ^ frame[1] ^ frame[2]) == frame[3]) begin
              exp_cmd  = 1'b1;
              exp_data = {frame[0], frame[1], frame[2]};
            end else begin
              bump_err();
            end
          end
        end
      end
      if (exp_valid && link.tx_ready) void'(txq.pop_front());
      // At most two frames (one in flight, one waiting) may be outstanding.
      if (i_reply) begin
        if ((txq.size() + 4) / 5 < 2) begin
          w = i_reply_data;
          txq.push_back(RS);
          txq.push_back(w[23:16]);
          txq.push_back(w[15:8]);
          txq.push_back(w[7:0]);
          txq.push_back(w[23:16] ^ w[15:8] ^ w[7:0]);
        end else begin
          exp_ovf = 1'b1;
        end
      end
      exp_valid = (txq.size() != 0);
      if (exp_valid) exp_byte = txq[0];
    end
    cyc++;
  endtask

  task automatic tick();
    if (rand_tx) begin
      i_reply       = ($urandom_range(0, 5) == 0);
      i_reply_data  = 24'($urandom);
      link.tx_ready = ($urandom_range(0, 3) != 0);
    end
    model_step();
    if (link.tx_valid === 1'b1 && link.tx_ready) sent_q.push_back(link.tx_byte);
    @(posedge clk);
    #1;
    check("command", 32'(o_command), 32'(exp_cmd));
    check("command_data", 32'(o_command_data), 32'(exp_data));
    check("error_count", 32'(o_error_count), 32'(exp_err));
    check("tx_valid", 32'(link.tx_valid), 32'(exp_valid));
    if (exp_valid) check("tx_byte", 32'(link.tx_byte), 32'(exp_byte));
    check("overflow", 32'(o_overflow), 32'(exp_ovf));
    if (o_command === 1'b1) n_cmd++;
    if (o_overflow === 1'b1) n_ovf++;
    link.rx_valid = 1'b0;
    i_reply       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic rx_send(input logic [7:0] b);
    link.rx_valid = 1'b1;
    link.rx_byte  = b;
    tick();
  endtask

  task automatic send5(input logic [39:0] f);
    for (int i = 0; i < 5; i++) rx_send(f[39-8*i -: 8]);
  endtask

  task automatic send_reply(input logic [23:0] d);
    i_reply      = 1'b1;
    i_reply_data = d;
    tick();
  endtask

  task automatic check_sent(input string tag);
    check({tag, "_len"}, 32'(sent_q.size()), 32'(want_q.size()));
    for (int i = 0; i < want_q.size(); i++)
      check(tag, (i < sent_q.size()) ? 32'(sent_q[i]) : 32'hFFFF_FFFF, 32'(want_q[i]));
  endtask

  initial begin
    int base;
    logic [23:0] d;
    logic [7:0]  c;
    link.rx_valid = 1'b0; link.rx_byte = '0; link.tx_ready = 1'b1;
    i_reply = 1'b0; i_reply_data = '0;
    rst = 1'b1;
    idle(2);
    check("reset_tx_byte", 32'(link.tx_byte), 32'h0);
    rst = 1'b0;

    // Valid frame back-to-back.
    base = n_cmd;
    send5(40'hA5_12_34_56_70);
    check("valid_cmd_pulse", 32'(o_command), 32'h1);
    check("valid_cmd_data", 32'(o_command_data), 32'h123456);
    idle(2);
    check("valid_cmd_count", 32'(n_cmd - base), 32'h1);
    check("valid_err", 32'(o_error_count), 32'h0);

    // Noise then bad checksum, then a good frame.
    base = n_cmd;
    rx_send(8'h00); rx_send(8'hFF);
    send5(40'hA5_12_34_56_71);
    idle(2);
    check("badchk_no_cmd", 32'(n_cmd - base), 32'h0);
    check("badchk_err", 32'(o_error_count), 32'h1);
    send5(40'hA5_00_00_01_01);
    check("after_bad_cmd", 32'(o_command_data), 32'h000001);

    // Timeout discards the partial frame.
    rx_send(CS); rx_send(8'h12);
    idle(T + 2);
    check("timeout_err", 32'(o_error_count), 32'h2);
    send5(40'hA5_AB_CD_EF_89);
    check("after_timeout_cmd", 32'(o_command_data), 32'hABCDEF);

    // Sync byte arriving in the very cycle the timeout fires starts a new frame.
    rx_send(CS); rx_send(8'h11);
    idle(T);
    send5(40'hA5_22_33_11_00);
    check("timeout_edge_cmd", 32'(o_command_data), 32'h223311);
    check("timeout_edge_err", 32'(o_error_count), 32'h3);

    // Byte spacing of exactly TIMEOUT_CYCLES is still accepted.
    rx_send(CS);
    for (int i = 0; i < 4; i++) begin
      idle(T - 1);
      rx_send(8'h44 + 8'(i) * 8'h11 + ((i == 3) ? 8'h00 : 8'h00) - ((i == 3) ? 8'h00 : 8'h00));
    end
    // Bytes sent above: 44 55 66 77; 44^55^66 == 77.
    check("spacing_cmd", 32'(o_command_data), 32'h445566);
    check("spacing_err", 32'(o_error_count), 32'h3);

    // Reply with alternating backpressure.
    sent_q.delete();
    send_reply(24'hABCDEF);
    for (int k = 0; k < 12; k++) begin
      link.tx_ready = (k % 2 == 0);
      tick();
    end
    want_q = '{8'h5A, 8'hAB, 8'hCD, 8'hEF, 8'h89};
    check_sent("bp_bytes");

    // Overflow on the third reply; the first two go out back-to-back.
    link.tx_ready = 1'b0;
    base = n_ovf;
    send_reply(24'h000001);
    send_reply(24'h000002);
    send_reply(24'h000003);
    check("ovf_pulse", 32'(o_overflow), 32'h1);
    sent_q.delete();
    link.tx_ready = 1'b1;
    idle(14);
    check("ovf_count", 32'(n_ovf - base), 32'h1);
    want_q = '{8'h5A, 8'h00, 8'h00, 8'h01, 8'h01, 8'h5A, 8'h00, 8'h00, 8'h02, 8'h02};
    check_sent("ovf_bytes");

    // Reset while transmitting B1 and receiving in D1.
    link.tx_ready = 1'b0;
    send_reply(24'h654321);
    link.tx_ready = 1'b1;
    idle(2);
    link.tx_ready = 1'b0;
    rx_send(CS); rx_send(8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_tx_valid", 32'(link.tx_valid), 32'h0);
    check("rst_tx_byte", 32'(link.tx_byte), 32'h0);
    check("rst_err", 32'(o_error_count), 32'h0);
    check("rst_cmd_data", 32'(o_command_data), 32'h0);
    link.tx_ready = 1'b1;
    send5(40'hA5_00_00_02_02);
    check("post_rst_cmd", 32'(o_command_data), 32'h000002);

    // Random traffic on both paths, with byte gaps clustered around the timeout.
    rand_tx = 1'b1;
    for (int f = 0; f < 300; f++) begin
      d = 24'($urandom);
      c = d[23:16] ^ d[15:8] ^ d[7:0];
      if ($urandom_range(0, 9) == 0) c = c ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) rx_send(8'($urandom));
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 15) == 0) idle($urandom_range(T - 2, T + 2));
        else idle($urandom_range(0, 2));
        case (i)
          0: rx_send(CS);
          1: rx_send(d[23:16]);
          2: rx_send(d[15:8]);
          3: rx_send(d[7:0]);
          default: rx_send(c);
        endcase
      end
    end
    rand_tx = 1'b0;
    link.tx_ready = 1'b1;
    idle(25);
    check("drain_idle", 32'(link.tx_valid), 32'h0);

    // Error counter saturates at 255.
    for (int f = 0; f < 260; f++) send5(40'hA5_00_00_00_01);
    check("err_saturate", 32'(o_error_count), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
